// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constants and the
// frame-width clamp used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_TICK = 8;

  localparam logic [3:0] MIN_WIDTH = 4'd5;
  localparam logic [3:0] MAX_WIDTH = 4'd8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Receiver internals made visible for debug and checker binding.
  typedef struct packed {
    logic [2:0] state;
    logic [3:0] tick_idx;
    logic [3:0] bit_cnt;
  } rx_dbg_t;

  // Out-of-range widths fall back to a full-width frame.
  function automatic logic [3:0] clamp_width(input logic [3:0] w);
    return ((w >= MIN_WIDTH) && (w <= MAX_WIDTH)) ? w : MAX_WIDTH;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every BASE_DIV * 2^(7-baud) clocks,
// with the phase realigned by restart.
module uart_baud_tick #(
  parameter int BASE_DIV = 27
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [2:0] baud,
  input  logic       restart,
  output logic       tick
);

  localparam int MAX_PERIOD = BASE_DIV * 128;
  localparam int CW         = $clog2(MAX_PERIOD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_m1;
  logic          wrap;

  assign period_m1 = (CW'(BASE_DIV) << (3'd7 - baud)) - CW'(1);
  // >= keeps the divider safe if baud shrinks while the count is high.
  assign wrap      = (cnt_q >= period_m1);
  assign tick      = wrap & ~restart;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || wrap) cnt_d = '0;
  end

  always_ff @(posedge pclk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deserialiser with parity/stop checking and
// a single-entry holding register. Define UART_RX_MAJORITY_EN for 3-sample voting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int BASE_DIV   = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [3:0]       bit_width,
  input  logic [2:0]       baud,
  input  logic             parity_odd,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output rx_dbg_t          dbg_o
);

  localparam int         IDXW      = $clog2(DSIZE);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, start_det, tick, bit_val;

  logic [2:0]       state_q, state_d;
  logic [3:0]       tick_idx_q, tick_idx_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       width_q, width_d;
  logic [2:0]       baud_q, baud_d;
  logic             odd_q, odd_d;
  logic             par_bad_q, par_bad_d;
  logic [DSIZE-1:0] shift_q, shift_d;
  logic             complete, stop_bad;

  logic [DSIZE-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  assign rx_s      = sync2_q;
  assign start_det = prev_q & ~sync2_q & (state_q == ST_IDLE);

  uart_baud_tick #(.BASE_DIV(BASE_DIV)) u_tick (
    .pclk    (pclk),
    .rst     (rst),
    .baud    (baud_q),
    .restart (start_det),
    .tick    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_TICK = 4'(SAMPLE_TICK + 1);
  logic [1:0] vote_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vote_q <= '0;
    end else if (tick && (tick_idx_q == 4'(SAMPLE_TICK - 1))) begin
      vote_q[0] <= rx_s;
    end else if (tick && (tick_idx_q == 4'(SAMPLE_TICK))) begin
      vote_q[1] <= rx_s;
    end
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (rx_s & (vote_q[0] | vote_q[1]));
`else
  localparam logic [3:0] DECIDE_TICK = 4'(SAMPLE_TICK);
  assign bit_val = rx_s;
`endif

  // Frame FSM. Leaving STOP at the sample point lets a back-to-back start
  // edge in the second half of the stop bit be caught.
  always_comb begin
    state_d    = state_q;
    tick_idx_d = tick_idx_q;
    bit_cnt_d  = bit_cnt_q;
    width_d    = width_q;
    baud_d     = baud_q;
    odd_d      = odd_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    complete   = 1'b0;
    stop_bad   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start_det) begin
        state_d    = ST_START;
        tick_idx_d = '0;
        bit_cnt_d  = '0;
        width_d    = clamp_width(bit_width);
        baud_d     = baud;
        odd_d      = parity_odd;
        shift_d    = '0;
        par_bad_d  = 1'b0;
      end
    end else if (tick) begin
      tick_idx_d = (tick_idx_q == TICK_LAST) ? 4'd0 : tick_idx_q + 4'd1;
      if (tick_idx_q == DECIDE_TICK) begin
        case (state_q)
          ST_START: state_d = bit_val ? ST_IDLE : ST_DATA;
          ST_DATA: begin
            shift_d[bit_cnt_q[IDXW-1:0]] = bit_val;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == (width_q - 4'd1)) state_d = ST_PARITY;
          end
          ST_PARITY: begin
            par_bad_d = (^shift_q) ^ bit_val ^ odd_q;
            state_d   = ST_STOP;
          end
          ST_STOP: begin
            complete = 1'b1;
            stop_bad = ~bit_val;
            state_d  = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Handshake: a word transfers on any cycle with rx_valid && rx_ready, and
  // rx_valid drops on the following edge unless a new word loads there.
  // A completion while the held word is stalled is dropped as an overrun.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (complete) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        parity_err_d = par_bad_q;
        frame_err_d  = stop_bad;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      tick_idx_q   <= '0;
      bit_cnt_q    <= '0;
      width_q      <= MAX_WIDTH;
      baud_q       <= 3'd7;
      odd_q        <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= rxd;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      tick_idx_q   <= tick_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      width_q      <= width_d;
      baud_q       <= baud_d;
      odd_q        <= odd_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign parity_err     = parity_err_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_o.state    = state_q;
  assign dbg_o.tick_idx = tick_idx_q;
  assign dbg_o.bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven from a bit-level model, expected
// words queued at stimulus time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_OFS = 9;
`else
  localparam int DECIDE_OFS = 8;
`endif

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [3:0] bit_width = 4'd8;
  logic [2:0] baud = 3'd7;
  logic       parity_odd = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;
  rx_dbg_t    dbg;

  uart_rx #(.DSIZE(8), .BASE_DIV(1), .OVERSAMPLE(16)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .rxd        (rxd),
    .bit_width  (bit_width),
    .baud       (baud),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy),
    .dbg_o      (dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 pclk = ~pclk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   presented = 0;
  logic word_seen = 1'b0;
  logic [9:0] exp_q[$];   // {frame_err, parity_err, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_width(input logic [3:0] bw);
    return (bw >= 4'd5 && bw <= 4'd8) ? int'(bw) : 8;
  endfunction

  // Parity bit a correct transmitter would send for these data bits.
  function automatic logic good_parity(input logic [7:0] d, input int w, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pclk);
    #2;
  endtask

  task automatic drive_bit(input logic b, input logic [2:0] bd);
    int n;
    n = 16 << (7 - int'(bd));
    rxd = b;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] bw, input logic odd,
                            input logic pbit, input logic sbit, input logic [2:0] bd,
                            input bit push, input bit scramble);
    int w;
    logic [7:0] dm;
    logic pe;
    w  = eff_width(bw);
    dm = d & 8'((1 << w) - 1);
    pe = (pbit != good_parity(dm, w, odd));
    bit_width  = bw;
    parity_odd = odd;
    baud       = bd;
    if (push) exp_q.push_back({~sbit, pe, dm});
    drive_bit(1'b0, bd);
    if (scramble) begin
      bit_width  = 4'($urandom);
      parity_odd = 1'($urandom);
      baud       = 3'($urandom);
    end
    for (int i = 0; i < w; i++) drive_bit(d[i], bd);
    drive_bit(pbit, bd);
    drive_bit(sbit, bd);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (busy !== lvl && n < 2000);
    check(name, busy, lvl);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge pclk);
      if (rst) begin
        word_seen = 1'b0;
      end else begin
        if (overrun) ovr_cnt++;
        if (rx_valid && !word_seen) begin
          presented++;
          word_seen = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got data 0x%0h pe %0b fe %0b, none queued",
                     rx_data, parity_err, frame_err);
          end else begin
            e = exp_q.pop_front();
            check("rx_word", {22'd0, frame_err, parity_err, rx_data}, {22'd0, e});
          end
        end
        if (rx_valid && rx_ready) word_seen = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ovr0, p0, w, n;
    logic saw;
    logic [7:0] d, dm;
    logic [3:0] bw;
    logic [2:0] bd;
    logic odd, sbit, wrong;

    repeat (3) @(posedge pclk);
    #2;
    @(negedge pclk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_perr", parity_err, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    check("reset_busy", busy, 0);
    step();
    rst = 1'b0;
    drive_bit(1'b1, 3'd7);

    // Basic word held until a one-cycle ready pulse.
    rx_ready = 1'b0;
    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 1, 0);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("a5_cleared", rx_valid, 0);
    rx_ready = 1'b1;

    // Width 5, odd parity: good then bad parity bit.
    send_frame(8'h15, 4'd5, 1'b1, 1'b0, 1'b1, 3'd7, 1, 0);
    send_frame(8'h15, 4'd5, 1'b1, 1'b1, 1'b1, 3'd7, 1, 0);
    drive_bit(1'b1, 3'd7);

    // Stop bit 0 followed by a held-low line.
    send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 3'd7, 1, 0);
    p0 = presented;
    repeat (48) step();
    check("break_no_word", presented, p0);
    check("break_idle", busy, 0);
    drive_bit(1'b1, 3'd7);
    send_frame(8'hC3, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 1, 0);
    drive_bit(1'b1, 3'd7);

    // Four-cycle low glitch on an idle line.
    p0 = presented;
    ovr0 = ovr_cnt;
    rxd = 1'b0;
    repeat (4) step();
    rxd = 1'b1;
    saw = 1'b0;
    n = 0;
    while (!saw && n < 8) begin
      @(negedge pclk);
      if (busy) saw = 1'b1;
      n++;
    end
    check("glitch_busy_rise", saw, 1);
    wait_busy(1'b0, "glitch_busy_fall");
    step();
    repeat (20) step();
    check("glitch_no_word", presented, p0);
    check("glitch_perr", parity_err, 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_no_ovr", ovr_cnt - ovr0, 0);

    // Back-to-back frames with the consumer stalled: second word dropped.
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 1, 0);
    send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 0, 0);
    drive_bit(1'b1, 3'd7);
    check("ovr_pulse_once", ovr_cnt - ovr0, 1);
    check("ovr_held_data", rx_data, 8'h11);
    check("ovr_held_valid", rx_valid, 1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;

    // Ready asserted exactly on the second completion cycle.
    ovr0 = ovr_cnt;
    fork
      begin
        send_frame(8'h11, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 1, 0);
        send_frame(8'h22, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 1, 0);
      end
      begin
        wait_busy(1'b1, "f1_busy");
        wait_busy(1'b0, "f1_done");
        wait_busy(1'b1, "f2_busy");
        repeat (16 * 10 + DECIDE_OFS) @(posedge pclk);
        #2;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
      end
    join
    drive_bit(1'b1, 3'd7);
    check("same_cycle_no_ovr", ovr_cnt - ovr0, 0);
    check("same_cycle_data", rx_data, 8'h22);
    check("same_cycle_valid", rx_valid, 1);

    // Reset in the middle of DATA while a word is held.
    send_frame(8'h77, 4'd8, 1'b0, 1'b1, 1'b1, 3'd7, 0, 0);
    bit_width = 4'd8;
    parity_odd = 1'b0;
    baud = 3'd7;
    drive_bit(1'b0, 3'd7);
    drive_bit(1'b0, 3'd7);
    drive_bit(1'b1, 3'd7);
    check("mid_busy", busy, 1);
    check("mid_state", dbg.state, ST_DATA);
    rst = 1'b1;
    rxd = 1'b1;
    step();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    step();
    rst = 1'b0;
    rx_ready = 1'b1;
    drive_bit(1'b1, 3'd7);
    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b1, 3'd7, 1, 0);
    drive_bit(1'b1, 3'd7);

    // Randomized frames: widths (incl. illegal), parity modes, bauds,
    // parity/stop errors, and config changes mid-frame.
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      n = $urandom_range(0, 5);
      bw = (n < 4) ? 4'(5 + n) : 4'($urandom_range(0, 15));
      odd = 1'($urandom);
      bd = 3'($urandom_range(5, 7));
      wrong = ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 5) != 0);
      w = eff_width(bw);
      dm = d & 8'((1 << w) - 1);
      send_frame(d, bw, odd, good_parity(dm, w, odd) ^ wrong, sbit, bd, 1, 1);
      if (!sbit || $urandom_range(0, 1) == 1) drive_bit(1'b1, bd);
    end
    drive_bit(1'b1, 3'd7);
    repeat (20) step();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
